// File: rtl/clk_period_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_monitor_pkg
//
// Shared types and helpers for the clock-period monitor.
//   cpm_state_e : measurement FSM states
//                   IDLE    - monitor disabled, nothing is counted
//                   ARM     - enabled, waiting for the first rising edge
//                   MEASURE - counting clk cycles between rising edges
//   in_tol()    : true when |period - exp| <= tol, evaluated without wrap
// -----------------------------------------------------------------------------
package clk_period_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } cpm_state_e;

  // Absolute-difference tolerance check. The operands are zero-extended into
  // a 33-bit difference, which covers any counter width up to 32 bits, so a
  // short period below the expected value never wraps into a huge unsigned
  // number and never slips past the comparison.
  function automatic logic in_tol(input logic [31:0] period,
                                  input logic [31:0] exp,
                                  input logic [31:0] tol);
    logic [32:0] diff;
    if (period >= exp) begin
      diff = {1'b0, period} - {1'b0, exp};
    end else begin
      diff = {1'b0, exp} - {1'b0, period};
    end
    return (diff <= {1'b0, tol});
  endfunction

endpackage : clk_period_monitor_pkg

// File: rtl/cpm_sync_edge.sv
// -----------------------------------------------------------------------------
// cpm_sync_edge
//
// Brings an asynchronous strobe into the clk domain and flags its rising edges.
// Path: d_i -> sync1_q -> sync2_q (metastability filter) -> prev_q.
// rise is combinational from the last two flops, so a rising edge on d_i is
// acted on by the consumer at the third clk edge after it arrives.
//
// Ports
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset (all flops cleared to 0)
//   d_i    in   asynchronous input
//   rise   out  one-cycle high when the synchronized input goes 0 -> 1
// -----------------------------------------------------------------------------
module cpm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the value
  // its neighbour held before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule : cpm_sync_edge

// File: rtl/clk_period_monitor.sv
// -----------------------------------------------------------------------------
// clk_period_monitor
//
// Synthesizable period checker for a slow clock/strobe sampled in clk.
// Counts clk cycles between successive rising edges of mon_in, compares each
// period against EXP_PERIOD +/- TOL, pulses pass/fail, keeps a saturating
// error count and a sticky stuck flag for downstream status/CSR logic.
//
// Parameters
//   CNT_W      width of the period counter and period_o
//   EXP_PERIOD expected period in clk cycles
//   TOL        allowed absolute deviation in cycles
//   TIMEOUT    cycles without a rising edge before stuck is declared
//              (must be < 2**CNT_W so the counter can reach it)
//   ERR_W      width of the error counter
//
// Ports
//   clk            in   sampling clock
//   rst_n          in   asynchronous active-low reset
//   en             in   monitor enable; low returns to IDLE, discarding counts
//   clr_i          in   synchronous clear of err_cnt_o, stuck_o (and min/max)
//   mon_in         in   monitored clock, asynchronous to clk
//   period_o       out  last measured period
//   period_valid_o out  one-cycle pulse when period_o updates
//   pass_o         out  pulse with period_valid_o when the period is in range
//   fail_o         out  pulse on an out-of-range period or on a timeout
//   stuck_o        out  sticky: a timeout has occurred
//   err_cnt_o      out  saturating count of fail events
//
// Optional build macro CLK_PERIOD_MONITOR_MINMAX_EN adds
//   min_o / max_o  out  smallest / largest valid period since reset or clr_i
//                       (reset/clear values: all-ones / zero)
// -----------------------------------------------------------------------------
module clk_period_monitor
  import clk_period_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 64,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_i,
  input  logic             mon_in,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             stuck_o,
  output logic [ERR_W-1:0] err_cnt_o
`ifdef CLK_PERIOD_MONITOR_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic rise;

  cpm_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (mon_in),
    .rise  (rise)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cpm_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             pass_q,   pass_d;
  logic             fail_q,   fail_d;
  logic             stuck_q,  stuck_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic             timeout;
  logic             period_ok;

`ifdef CLK_PERIOD_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
`endif

  // On a rise in MEASURE, cnt_q already holds the number of clk cycles since
  // the previous accepted edge (it restarts at 1 on the cycle after an edge).
  assign period_ok = in_tol(32'(cnt_q), 32'(EXP_PERIOD), 32'(TOL));

  // ---------------------------------------------------------------------------
  // Next-state and pulse generation
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = ARM;
        end
      end

      ARM: begin
        // The first edge after arming only opens a measurement window.
        cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end

      MEASURE: begin
        // A rise on the timeout cycle is a genuine edge and takes priority.
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = CNT_ONE;
          valid_d  = 1'b1;
          pass_d   = period_ok;
          fail_d   = ~period_ok;
        end else if (cnt_q == TIMEOUT_C) begin
          timeout = 1'b1;
          fail_d  = 1'b1;
          state_d = ARM;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable overrides everything: the partial count is dropped silently and
    // the next enable must see two edges before a period is reported.
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = period_q;
      valid_d  = 1'b0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      timeout  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status accumulation; clr_i wins over a same-cycle fail or timeout, but the
  // fail pulse itself is still emitted.
  // ---------------------------------------------------------------------------
  always_comb begin
    stuck_d = stuck_q | timeout;
    err_d   = err_q;
    if (fail_d && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end
    if (clr_i) begin
      stuck_d = 1'b0;
      err_d   = '0;
    end
  end

`ifdef CLK_PERIOD_MONITOR_MINMAX_EN
  // Extremes follow valid periods only; timeouts never carry a period.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (valid_d) begin
      if (period_d < min_q) begin
        min_d = period_d;
      end
      if (period_d > max_q) begin
        max_d = period_d;
      end
    end
    if (clr_i) begin
      min_d = '1;
      max_d = '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      stuck_q  <= stuck_d;
      err_q    <= err_d;
    end
  end

`ifdef CLK_PERIOD_MONITOR_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (pass and fail come from complementary terms of one compare, so
  // they can never be high together)
  // ---------------------------------------------------------------------------
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign stuck_o        = stuck_q;
  assign err_cnt_o      = err_q;

endmodule : clk_period_monitor
